// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared-ALU arbiter:
//   op_t    - 2-bit ALU operation encoding (AND/OR/ADD/SUB)
//   state_t - arbiter FSM states (IDLE -> EXEC -> RESP -> IDLE)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority select. Scans the request vector
// starting at i_ptr and wrapping upward; the first set bit wins.
// Ports:
//   i_req   [NREQ-1:0] request vector
//   i_ptr   [IDW-1:0]  highest-priority index
//   o_any              at least one request present
//   o_grant [NREQ-1:0] one-hot grant (all-zero when o_any is low)
//   o_idx   [IDW-1:0]  index of the granted request
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic            o_any,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        o_any   = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        // NREQ is a power of two, so the IDW-bit add wraps naturally.
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_cand = i_ptr + IDW'(i);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Round-robin scheduler sharing one W-bit ALU (AND/OR/ADD/SUB) among NREQ
// requesters. One operation is accepted in IDLE, executed in EXEC and the
// tagged result is held in RESP until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid [NREQ-1:0]       per-requester operation pending
//   req_op    [2*NREQ-1:0]     per-requester op (2 bits each)
//   req_a/b   [W*NREQ-1:0]     per-requester operands (W bits each)
//   req_ready [NREQ-1:0]       one-hot acceptance (IDLE only)
//   rsp_valid/rsp_id/rsp_data  registered response, held until rsp_ready
//   rsp_ready                  consumer accepts the response
//   busy                       high whenever the FSM is not in IDLE
// Optional (macro ALU_SHARE_FLAGS_EN):
//   rsp_cout  ADD carry-out / SUB no-borrow (A >= B), 0 for AND/OR
//   rsp_zero  result equals zero
// ---------------------------------------------------------------------------
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int W    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_op,
    input  logic [W*NREQ-1:0] req_a,
    input  logic [W*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_data,
    input  logic              rsp_ready,
`ifdef ALU_SHARE_FLAGS_EN
    output logic              rsp_cout,
    output logic              rsp_zero,
`endif
    output logic              busy
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_gid;
    op_t            r_op;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [W-1:0]   r_rsp_data;

    logic            w_any;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic [1:0]      w_sel_op;
    logic [W-1:0]    w_sel_a;
    logic [W-1:0]    w_sel_b;
    logic [W-1:0]    w_res;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_any   (w_any),
        .o_grant (w_grant),
        .o_idx   (w_gidx)
    );

    // Operand mux for the winning requester
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gidx) begin
                w_sel_op = req_op[2*i +: 2];
                w_sel_a  = req_a[W*i +: W];
                w_sel_b  = req_b[W*i +: W];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and acceptance
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    // Gated by rst_n so ready reads 0 while reset is held.
                    req_ready   = w_grant & {NREQ{rst_n}};
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: w_state_nxt = S_RESP;
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared ALU on the latched operands
    always_comb begin
        w_res = '0;
        case (r_op)
            OP_AND:  w_res = r_a & r_b;
            OP_OR:   w_res = r_a | r_b;
            OP_ADD:  w_res = r_a + r_b;
            OP_SUB:  w_res = r_a - r_b;
            default: w_res = '0;
        endcase
    end

`ifdef ALU_SHARE_FLAGS_EN
    logic w_cout;
    logic r_rsp_cout;
    logic r_rsp_zero;

    // ADD carries exactly when the truncated sum wraps below A.
    always_comb begin
        w_cout = 1'b0;
        case (r_op)
            OP_ADD:  w_cout = (w_res < r_a);
            OP_SUB:  w_cout = (r_a >= r_b);
            default: w_cout = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_cout <= 1'b0;
            r_rsp_zero <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_rsp_cout <= w_cout;
            r_rsp_zero <= (w_res == '0);
        end
    end

    assign rsp_cout = r_rsp_cout;
    assign rsp_zero = r_rsp_zero;
`endif

    // Datapath: operand latch, response register, round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_gid       <= '0;
            r_op        <= OP_AND;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gid <= w_gidx;
                        r_op  <= op_t'(w_sel_op);
                        r_a   <= w_sel_a;
                        r_b   <= w_sel_b;
                    end
                end
                S_EXEC: begin
                    r_rsp_data  <= w_res;
                    r_rsp_id    <= r_gid;
                    r_rsp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= r_gid + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin scheduler that shares one W-bit ALU (AND/OR/ADD/SUB) among NREQ requesters. Each requester issues one operation through a valid/ready handshake. The block latches the winner's operands, executes once, and returns a tagged result through a valid/ready response port. It sits between the lab's requester blocks (switch/FSM front ends) and the shared ALU datapath.

## Interface
- `W`, 4: operand and result width
- `NREQ`, 4: number of requesters (≥2, power of two)
- `IDW`, log2(NREQ): requester ID width
- `clk` in 1: single clock; all state updates on the rising edge
- `rst_n` in 1: reset, asynchronous and active-low
- `req_valid` in NREQ: bit i = requester i has an operation pending
- `req_op` in 2·NREQ: slice [2i+1:2i] = op of requester i
- `req_a` in W·NREQ: slice [W(i+1)-1:Wi] = operand A of requester i
- `req_b` in W·NREQ: slice [W(i+1)-1:Wi] = operand B of requester i
- `req_ready` out NREQ: one-hot acceptance; a transfer occurs when `req_valid[i] & req_ready[i]`
- `rsp_valid` out 1: result available
- `rsp_id` out IDW: index of the requester that owns the result
- `rsp_data` out W: result
- `rsp_ready` in 1: consumer accepts the result
- `busy` out 1: high whenever state ≠ IDLE

## Operation
- Op encoding: 00 AND, 01 OR, 10 ADD (mod 2^W), 11 SUB (A−B mod 2^W).
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE:** if any `req_valid` bit is set, choose the first set bit scanning from `ptr` upward with wrap. Drive `req_ready[g]=1` combinationally in the same cycle. Latch op/A/B and g. Go to EXEC.
- **EXEC:** compute the result from the latched operands. Register it into `rsp_data`/`rsp_id`. Set `rsp_valid`. Go to RESP.
- **RESP:** hold `rsp_valid`, `rsp_data` and `rsp_id` stable until `rsp_ready`. On the handshake, clear `rsp_valid`, set `ptr ← (g+1) mod NREQ`, and go to IDLE.
- `req_ready` is all-zero outside IDLE. At most one bit is ever set.
- Requesters keep op and operands stable while valid is high and ready is low. The block never deasserts ready mid-transfer.
- The pointer advances only on response completion. A requester is never granted twice in a row while any other requester is valid.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0, state=IDLE, `ptr`=0.
- Latency: request accepted at edge N. `rsp_valid` rises after edge N+1.
- With `rsp_ready` held high, one operation completes every 3 cycles; the next grant occurs in the cycle after the response handshake.
- All requesters valid: grants cycle 0,1,2,3,0,… starting from reset.
- `ptr` wraps from NREQ−1 to 0.
- `rsp_ready` low stalls in RESP indefinitely. Inputs are ignored during the stall.
- `rsp_ready` high outside RESP has no effect.
- Reset asserted mid-operation clears everything immediately. The in-flight operation is discarded with no response.

## Configuration
- `ALU_SHARE_FLAGS_EN` defined: adds outputs `rsp_cout` (out 1) and `rsp_zero` (out 1), registered with `rsp_data` and reset to 0.
  - `rsp_cout`: ADD carry-out; for SUB, 1 when A ≥ B unsigned (no borrow); 0 for AND/OR.
  - `rsp_zero`: 1 when `rsp_data` is 0.
- Macro undefined: these ports and their logic are absent. Everything else is identical.

## Structure
- Shared package `alu_pkg`:
  - op encoding constants (`OP_AND`, `OP_OR`, `OP_ADD`, `OP_SUB`) and the 2-bit op typedef
  - FSM state typedef (`S_IDLE`, `S_EXEC`, `S_RESP`)
- One sub-module, `rr_pick`: combinational round-robin priority select.
  - Inputs: request vector, `ptr`.
  - Outputs: `any`, one-hot grant, grant index.
- The ALU operation is a case statement inside the block and is not instantiated separately.

## Test plan
- **Reset:** assert `rst_n`=0 mid-RESP → all outputs 0 immediately. After release, `busy`=0 and the first grant goes to requester 0 when all are valid.
- **Single request:** requester 2: op=ADD, A=4'h9, B=4'h8, `rsp_ready`=1 → `req_ready`=4'b0100 for one cycle. `rsp_valid` 2 cycles later with `rsp_data`=4'h1, `rsp_id`=2, and `rsp_cout`=1 if the flags macro is defined.
- **Fairness:** all 4 requesters valid continuously, `rsp_ready`=1 → `rsp_id` sequence 0,1,2,3,0 with responses 3 cycles apart.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`/`rsp_data`/`rsp_id` stable and `req_ready`=0 throughout. Completes in the cycle `rsp_ready`=1.
- **Ops:** requester 1: A=4'h5, B=4'h7 with AND/OR/SUB → 4'h5 / 4'h7 / 4'hE. For SUB, `rsp_cout`=0. A=B=4'h3 with SUB → 4'h0 with `rsp_zero`=1.
- **Wrap:** `ptr`=3 with requesters 0 and 3 valid → grant 3, then 0.
